// File: rtl/vliw_hazard_scoreboard_if.sv
// Decode-to-scoreboard bundle interface.
// master: decode side, drives the bundle fields and flush, observes stall/pending/stall_cycles.
// slave : scoreboard side.
interface vliw_hazard_scoreboard_if #(
    parameter int unsigned NREG = 8
);
    logic            flush;
    logic            id_valid;
    logic            id_alu_regWrite;
    logic [2:0]      id_alu_rd;
    logic [2:0]      id_alu_rm;
    logic [2:0]      id_alu_rn;
    logic            id_alu_uses_rm;
    logic            id_alu_uses_rn;
    logic            id_alu_setsN;
    logic            id_mem_load;
    logic            id_mem_store;
    logic [2:0]      id_mem_rd;
    logic [2:0]      id_mem_rn;
    logic            id_mem_uses_rn;
    logic            id_reads_N;
    logic            stall;
    logic [NREG-1:0] pending;
    logic [15:0]     stall_cycles;

    modport master (
        output flush, id_valid, id_alu_regWrite, id_alu_rd, id_alu_rm, id_alu_rn,
               id_alu_uses_rm, id_alu_uses_rn, id_alu_setsN, id_mem_load, id_mem_store,
               id_mem_rd, id_mem_rn, id_mem_uses_rn, id_reads_N,
        input  stall, pending, stall_cycles
    );

    modport slave (
        input  flush, id_valid, id_alu_regWrite, id_alu_rd, id_alu_rm, id_alu_rn,
               id_alu_uses_rm, id_alu_uses_rn, id_alu_setsN, id_mem_load, id_mem_store,
               id_mem_rd, id_mem_rn, id_mem_uses_rn, id_reads_N,
        output stall, pending, stall_cycles
    );
endinterface

// File: rtl/vliw_hazard_scoreboard.sv
// VLIW producer-side hazard scoreboard.
// Tracks per-register and N-flag countdowns after ALU/MEM writes and stalls decode
// while a bundle reads a value not yet reachable through forwarding.
// Ports: clk, reset (sync, active-high), bus (slave modport: bundle fields and flush in;
//        stall (combinational), pending, stall_cycles out).
module vliw_hazard_scoreboard #(
    parameter int unsigned NREG         = 8,
    parameter int unsigned ALU_FWD_LAT  = 0,
    parameter int unsigned LOAD_FWD_LAT = 1,
    parameter int unsigned N_FWD_LAT    = 1,
    parameter int unsigned CW           = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    vliw_hazard_scoreboard_if.slave bus
);
    localparam int unsigned RW           = 3;
    localparam int unsigned SCW          = 16;
    localparam int unsigned DUAL_FWD_LAT = (ALU_FWD_LAT > LOAD_FWD_LAT) ? ALU_FWD_LAT : LOAD_FWD_LAT;
    localparam logic [CW-1:0] ALU_LAT    = CW'(ALU_FWD_LAT);
    localparam logic [CW-1:0] LOAD_LAT   = CW'(LOAD_FWD_LAT);
    localparam logic [CW-1:0] DUAL_LAT   = CW'(DUAL_FWD_LAT);
    localparam logic [CW-1:0] N_LAT      = CW'(N_FWD_LAT);

    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic [CW-1:0]   ncnt_q;
    logic [CW-1:0]   ncnt_d;
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [SCW-1:0]  stall_cycles_q;
    logic            stall_c;
    logic            accept_c;

    // Hazard detection against the counts as they stand before this bundle's own writes.
    always_comb begin
        stall_c = 1'b0;
        if (bus.id_alu_uses_rm && (cnt_q[bus.id_alu_rm] != '0)) stall_c = 1'b1;
        if (bus.id_alu_uses_rn && (cnt_q[bus.id_alu_rn] != '0)) stall_c = 1'b1;
        if (bus.id_mem_uses_rn && (cnt_q[bus.id_mem_rn] != '0)) stall_c = 1'b1;
        if (bus.id_mem_store   && (cnt_q[bus.id_mem_rd] != '0)) stall_c = 1'b1;
        if (bus.id_reads_N     && (ncnt_q != '0))               stall_c = 1'b1;
        stall_c  = stall_c & bus.id_valid;
        accept_c = bus.id_valid & ~stall_c & ~bus.flush;
    end

    // Counter next state: flush clears, accepted writes reload, everything else counts down.
    always_comb begin
        ncnt_d    = ncnt_q;
        pending_d = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        if (bus.flush) begin
            ncnt_d = '0;
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_d[r] = '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (accept_c && bus.id_alu_regWrite && (bus.id_alu_rd == RW'(r)) &&
                    bus.id_mem_load && (bus.id_mem_rd == RW'(r))) begin
                    cnt_d[r] = DUAL_LAT;
                end else if (accept_c && bus.id_alu_regWrite && (bus.id_alu_rd == RW'(r))) begin
                    cnt_d[r] = ALU_LAT;
                end else if (accept_c && bus.id_mem_load && (bus.id_mem_rd == RW'(r))) begin
                    cnt_d[r] = LOAD_LAT;
                end else if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - CW'(1);
                end
            end
            if (accept_c && bus.id_alu_setsN) begin
                ncnt_d = N_LAT;
            end else if (ncnt_q != '0) begin
                ncnt_d = ncnt_q - CW'(1);
            end
        end
        for (int unsigned r = 0; r < NREG; r++) begin
            pending_d[r] = (cnt_d[r] != '0);
        end
    end

    // State registers; reset overrides flush and issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            ncnt_q         <= '0;
            pending_q      <= '0;
            stall_cycles_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            ncnt_q    <= ncnt_d;
            pending_q <= pending_d;
            if (stall_c && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + SCW'(1);
            end
        end
    end

    assign bus.stall        = stall_c;
    assign bus.pending      = pending_q;
    assign bus.stall_cycles = stall_cycles_q;
endmodule
